// File: rtl/ysyx_22050039_store_buffer_if.sv
// Bus bundle for the store buffer: EXU store request channel, data-memory
// write channel, load hazard query and fence handshake.
// slave  = the store buffer itself; master = the core/memory environment.
interface ysyx_22050039_store_buffer_if #(
    parameter int XLEN = 64
);
    logic            st_valid;
    logic            st_ready;
    logic [1:0]      st_size;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;

    logic            mem_wvalid;
    logic            mem_wready;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;

    logic [XLEN-1:0] ld_addr;
    logic            ld_hazard;

    logic            fence_req;
    logic            fence_done;
    logic            st_misalign;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_wready, ld_addr, fence_req,
        output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, ld_hazard,
               fence_done, st_misalign
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_wready, ld_addr, fence_req,
        input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, ld_hazard,
               fence_done, st_misalign
    );
endinterface

// File: rtl/ysyx_22050039_store_buffer.sv
// In-order store buffer: converts sb/sh/sw/sd into 8-byte-aligned masked
// writes, queues them in a DEPTH-entry circular FIFO, drains them over a
// valid/ready write port, flags loads that hit a pending word, and answers
// fence requests once the queue is empty.
// Optional feature macro: YSYX_22050039_MISALIGN_CHECK_EN -- when defined,
// misaligned stores are handshaken but dropped and st_misalign pulses.
module ysyx_22050039_store_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    ysyx_22050039_store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = XLEN - 3;

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

    logic [AW-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [7:0]      mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    state_e          state_q;
    logic            fence_done_q;
    logic            st_fire;
    logic            push;
    logic            pop;
    logic            misaligned;
    logic            hazard;
    logic            unused_ld_lsb;

    // Byte-lane enables: 2^size contiguous lanes starting at the byte offset.
    // Lanes shifted past lane 7 fall off the 8-bit result.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Move right-aligned store data into its byte lanes.
    function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

`ifdef YSYX_22050039_MISALIGN_CHECK_EN
    // A store is misaligned when its address is not a multiple of its size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    assign misaligned = is_misaligned(bus.st_size, bus.st_addr[2:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign st_fire = bus.st_valid && bus.st_ready;
    assign push    = st_fire && !misaligned;
    assign pop     = bus.mem_wvalid && bus.mem_wready;

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control: pointers, occupancy count and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + PW'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Entry storage: written on accept only; occupancy is tracked by valid_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.st_addr[XLEN-1:3];
            data_q[wr_ptr_q] <= lane_data(bus.st_data, bus.st_addr[2:0]);
            mask_q[wr_ptr_q] <= lane_mask(bus.st_size, bus.st_addr[2:0]);
        end
    end

    // Fence FSM: DRAIN blocks new stores until the queue empties, then pulses done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            fence_done_q <= 1'b0;
        end else begin
            fence_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.fence_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_d == '0) begin
                        fence_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef YSYX_22050039_MISALIGN_CHECK_EN
    logic misalign_q;

    // One-cycle pulse after a dropped misaligned store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= st_fire && misaligned;
        end
    end

    assign bus.st_misalign = misalign_q;
`else
    assign bus.st_misalign = 1'b0;
`endif

    // Load hazard: any occupied slot holding the same 8-byte word as the load.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.ld_addr[XLEN-1:3])) begin
                hazard = 1'b1;
            end
        end
    end

    assign unused_ld_lsb = ^bus.ld_addr[2:0];

    assign bus.st_ready   = (count_q != CW'(DEPTH)) && (state_q == IDLE);
    assign bus.mem_wvalid = (count_q != '0);
    // Head entry straight from storage; forced to zero while the queue is empty.
    assign bus.mem_waddr  = bus.mem_wvalid ? {addr_q[rd_ptr_q], 3'b000} : '0;
    assign bus.mem_wdata  = bus.mem_wvalid ? data_q[rd_ptr_q] : '0;
    assign bus.mem_wmask  = bus.mem_wvalid ? mask_q[rd_ptr_q] : '0;
    assign bus.ld_hazard  = hazard;
    assign bus.fence_done = fence_done_q;
endmodule

// File: tb/tb_ysyx_22050039_store_buffer.sv
// Directed bench for the store buffer with a write scoreboard: each accepted
// store pushes its hand-computed memory write, and a monitor pops and compares
// on every memory handshake.
module tb_ysyx_22050039_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } exp_t;

    exp_t exp_q[$];

    ysyx_22050039_store_buffer_if #(.XLEN(64)) bus ();

    ysyx_22050039_store_buffer #(.XLEN(64), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one store and hold it until accepted (bounded).
    task automatic do_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                            input bit exp_en, input logic [63:0] ea, input logic [63:0] ed,
                            input logic [7:0] em);
        bit acc;
        acc = 1'b0;
        bus.st_valid = 1'b1;
        bus.st_size  = sz;
        bus.st_addr  = a;
        bus.st_data  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.st_ready;
            step();
        end
        bus.st_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL store_accept: addr 0x%0h got no accept within 50 cycles, required accept", a);
        end else if (exp_en) begin
            exp_q.push_back(exp_t'{ea, ed, em});
        end
    endtask

    // Scoreboard monitor: compare every memory write against the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.mem_wvalid && bus.mem_wready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr 0x%0h mask 0x%0h, required no write",
                         bus.mem_waddr, bus.mem_wmask);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_waddr, e.a);
                chk("wr_data", bus.mem_wdata, e.d);
                chk("wr_mask", {56'd0, bus.mem_wmask}, {56'd0, e.m});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid   = 1'b0;
        bus.st_size    = 2'b00;
        bus.st_addr    = '0;
        bus.st_data    = '0;
        bus.mem_wready = 1'b0;
        bus.ld_addr    = '0;
        bus.fence_req  = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b1;
        chk("rst_wvalid", {63'd0, bus.mem_wvalid}, 64'd0);
        chk("rst_fence_done", {63'd0, bus.fence_done}, 64'd0);
        chk("rst_misalign", {63'd0, bus.st_misalign}, 64'd0);
        chk("rst_hazard", {63'd0, bus.ld_hazard}, 64'd0);
        chk("rst_waddr", bus.mem_waddr, 64'd0);
        chk("rst_wdata", bus.mem_wdata, 64'd0);
        chk("rst_wmask", {56'd0, bus.mem_wmask}, 64'd0);
        chk("rst_st_ready", {63'd0, bus.st_ready}, 64'd1);

        // sb into lane 5, visible the cycle after accept
        do_store(2'b00, 64'h8000_0005, 64'hAB, 1'b1,
                 64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20);
        chk("sb_wvalid_next", {63'd0, bus.mem_wvalid}, 64'd1);
        bus.mem_wready = 1'b1;
        step();
        bus.mem_wready = 1'b0;
        chk("sb_drained", {63'd0, bus.mem_wvalid}, 64'd0);

        // Four sd fill the buffer, then drain in order one per cycle
        do_store(2'b11, 64'h8000_0000, 64'h1111_1111_1111_1111, 1'b1, 64'h8000_0000, 64'h1111_1111_1111_1111, 8'hFF);
        do_store(2'b11, 64'h8000_0008, 64'h2222_2222_2222_2222, 1'b1, 64'h8000_0008, 64'h2222_2222_2222_2222, 8'hFF);
        do_store(2'b11, 64'h8000_0010, 64'h3333_3333_3333_3333, 1'b1, 64'h8000_0010, 64'h3333_3333_3333_3333, 8'hFF);
        do_store(2'b11, 64'h8000_0018, 64'h4444_4444_4444_4444, 1'b1, 64'h8000_0018, 64'h4444_4444_4444_4444, 8'hFF);
        chk("full_st_ready", {63'd0, bus.st_ready}, 64'd0);
        bus.ld_addr = 64'h8000_001C;
        #1;
        chk("full_hazard_tail", {63'd0, bus.ld_hazard}, 64'd1);
        bus.mem_wready = 1'b1;
        step();
        chk("ready_after_pop", {63'd0, bus.st_ready}, 64'd1);
        step();
        step();
        step();
        chk("drain4_empty", {63'd0, bus.mem_wvalid}, 64'd0);
        chk("drain4_sb_left", 64'(exp_q.size()), 64'd0);

        // Back-to-back sw/sh/sb with memory always ready (push and pop together)
        do_store(2'b10, 64'h8000_0104, 64'hDEAD_BEEF, 1'b1, 64'h8000_0100, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        do_store(2'b01, 64'h8000_0002, 64'h0000_0000_0000_BEEF, 1'b1, 64'h8000_0000, 64'h0000_0000_BEEF_0000, 8'h0C);
        chk("stream_wvalid", {63'd0, bus.mem_wvalid}, 64'd1);
        do_store(2'b00, 64'h8000_0011, 64'hFFFF_FFFF_FFFF_FF5A, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_5A00, 8'h02);
        step();
        bus.mem_wready = 1'b0;
        chk("stream_empty", {63'd0, bus.mem_wvalid}, 64'd0);

        // Load hazard on the same 8-byte word only
        bus.ld_addr = 64'h8000_0100;
        #1;
        chk("hazard_empty", {63'd0, bus.ld_hazard}, 64'd0);
        do_store(2'b10, 64'h8000_0104, 64'hCAFE_F00D, 1'b1, 64'h8000_0100, 64'hCAFE_F00D_0000_0000, 8'hF0);
        chk("hazard_hit", {63'd0, bus.ld_hazard}, 64'd1);
        bus.ld_addr = 64'h8000_0108;
        #1;
        chk("hazard_next_word", {63'd0, bus.ld_hazard}, 64'd0);
        bus.ld_addr = 64'h8000_0100;
        bus.mem_wready = 1'b1;
        step();
        bus.mem_wready = 1'b0;
        chk("hazard_after_drain", {63'd0, bus.ld_hazard}, 64'd0);

        // Fence with two pending entries
        do_store(2'b11, 64'h8000_0200, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h8000_0200, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_store(2'b00, 64'h8000_0201, 64'h77, 1'b1, 64'h8000_0200, 64'h7700, 8'h02);
        bus.fence_req  = 1'b1;
        bus.mem_wready = 1'b1;
        step();
        chk("drain_st_ready", {63'd0, bus.st_ready}, 64'd0);
        chk("drain_no_done_yet", {63'd0, bus.fence_done}, 64'd0);
        step();
        chk("fence_done_pulse", {63'd0, bus.fence_done}, 64'd1);
        chk("fence_empty", {63'd0, bus.mem_wvalid}, 64'd0);
        chk("fence_back_idle", {63'd0, bus.st_ready}, 64'd1);
        bus.fence_req  = 1'b0;
        bus.mem_wready = 1'b0;
        step();
        chk("fence_done_single", {63'd0, bus.fence_done}, 64'd0);

        // Fence on an empty buffer: done two cycles after request
        bus.fence_req = 1'b1;
        step();
        chk("efence_drain_ready", {63'd0, bus.st_ready}, 64'd0);
        chk("efence_not_yet", {63'd0, bus.fence_done}, 64'd0);
        step();
        chk("efence_done", {63'd0, bus.fence_done}, 64'd1);
        bus.fence_req = 1'b0;
        step();
        chk("efence_done_low", {63'd0, bus.fence_done}, 64'd0);

        // Reset with a full buffer discards everything
        do_store(2'b11, 64'h8000_0300, 64'hA, 1'b0, '0, '0, '0);
        do_store(2'b11, 64'h8000_0308, 64'hB, 1'b0, '0, '0, '0);
        do_store(2'b11, 64'h8000_0310, 64'hC, 1'b0, '0, '0, '0);
        do_store(2'b11, 64'h8000_0318, 64'hD, 1'b0, '0, '0, '0);
        chk("prerst_full", {63'd0, bus.st_ready}, 64'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.ld_addr = 64'h8000_0308;
        #1;
        chk("midrst_wvalid", {63'd0, bus.mem_wvalid}, 64'd0);
        chk("midrst_st_ready", {63'd0, bus.st_ready}, 64'd1);
        chk("midrst_hazard", {63'd0, bus.ld_hazard}, 64'd0);
        bus.mem_wready = 1'b1;
        step();
        step();
        step();
        chk("midrst_no_write", {63'd0, bus.mem_wvalid}, 64'd0);
        bus.mem_wready = 1'b0;

        // Misaligned sh at lane 7
`ifdef YSYX_22050039_MISALIGN_CHECK_EN
        do_store(2'b01, 64'h8000_0007, 64'hBBAA, 1'b0, '0, '0, '0);
        chk("misalign_pulse", {63'd0, bus.st_misalign}, 64'd1);
        chk("misalign_no_write", {63'd0, bus.mem_wvalid}, 64'd0);
        step();
        chk("misalign_pulse_end", {63'd0, bus.st_misalign}, 64'd0);
`else
        do_store(2'b01, 64'h8000_0007, 64'hBBAA, 1'b1, 64'h8000_0000, 64'hAA00_0000_0000_0000, 8'h80);
        chk("misalign_tied_low", {63'd0, bus.st_misalign}, 64'd0);
        chk("misalign_wvalid", {63'd0, bus.mem_wvalid}, 64'd1);
        bus.mem_wready = 1'b1;
        step();
        bus.mem_wready = 1'b0;
`endif
        step();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22050039_store_buffer.md
# ysyx_22050039_store_buffer

Store-side counterpart of the execute unit's load path. It accepts store requests (sb/sh/sw/sd) from the EXU, converts each into an 8-byte-aligned memory write with a byte mask, and queues it in a small in-order FIFO. The FIFO drains to the data-memory write port over a valid/ready handshake. The block also reports load-vs-pending-store hazards and answers fence/drain requests.

## Interface
- XLEN, 64: data/address width; only 64 is supported.
- DEPTH, 4: FIFO entries; power of two, at least 2.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept a store
- st_size  in  2  00=byte, 01=half, 10=word, 11=double
- st_addr  in  XLEN  byte address
- st_data  in  XLEN  store data, right-aligned (low bytes significant)
- mem_wvalid  out  1  head entry valid toward memory
- mem_wready  in  1  memory accepts head entry
- mem_waddr  out  XLEN  {addr[63:3], 3'b000}
- mem_wdata  out  XLEN  data shifted into byte lanes
- mem_wmask  out  8  byte-lane enables
- ld_addr  in  XLEN  address of the load currently in EXU
- ld_hazard  out  1  a pending entry hits the same 8-byte word as ld_addr
- fence_req  in  1  level; request drain
- fence_done  out  1  one-cycle pulse when drain completes
- st_misalign  out  1  one-cycle pulse on a rejected misaligned store (macro only)

## Operation
- Store accept: st_valid && st_ready at a rising edge.
- st_ready = (count != DEPTH) && (state == IDLE). No same-cycle bypass when full.
- Entry formation at accept:
  - off = addr[2:0]
  - mask = ({8{1'b1}} >> (8 - 2^size)) << off, truncated to 8 bits
  - wdata = st_data << (8*off), truncated to XLEN
  - waddr = addr with bits [2:0] cleared
- FIFO: circular, with rd_ptr and wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus count of log2(DEPTH)+1 bits.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Memory side:
  - mem_wvalid = (count != 0).
  - mem_w* present the head entry straight from storage.
  - Head is popped on mem_wvalid && mem_wready.
  - Once mem_wvalid is asserted, the head must not change until it is accepted.
- ld_hazard: combinational OR over all occupied entries of (entry.waddr[63:3] == ld_addr[63:3]). It is 0 when empty. Entries are not forwarded; the core stalls the load while ld_hazard is high.
- FSM, 2 states:
  - IDLE: on fence_req go to DRAIN.
  - DRAIN: st_ready = 0. When count == 0 (including count reaching 0 this cycle via a pop), pulse fence_done for one cycle and return to IDLE.
  - If fence_req arrives while the buffer is already empty, go IDLE→DRAIN, then pulse fence_done the next cycle (2-cycle minimum).

## Timing
- Reset (rst == 0 at an edge) values:
  - count = 0, rd_ptr = 0, wr_ptr = 0, state = IDLE
  - mem_wvalid = 0, fence_done = 0, st_misalign = 0, ld_hazard = 0
  - mem_waddr/mem_wdata/mem_wmask = 0
- Reset mid-operation discards every pending entry; no write is issued afterward.
- Accept-to-memory latency: a store accepted at edge N into an empty buffer drives mem_wvalid = 1 in cycle N+1.
- Throughput: one accept and one pop per cycle.
- ld_hazard reflects the post-edge FIFO contents. A store accepted at edge N affects ld_hazard starting in cycle N+1.
- st_misalign pulses in the cycle after the rejected handshake.

## Configuration
- YSYX_22050039_MISALIGN_CHECK_EN
  - Defined: a store whose address is not a multiple of its size (half: addr[0]; word: addr[1:0]; double: addr[2:0]) is still handshaken (st_ready unaffected) but is not enqueued, and st_misalign pulses.
  - Undefined: every store is enqueued. Mask/data bits shifted beyond lane 7 are silently dropped; st_misalign is tied to 0.

## Test plan
- sb, addr 0x8000_0005, data 0xAB → mem_waddr 0x8000_0000, mem_wmask 0x20, mem_wdata 0x0000_AB00_0000_0000, mem_wvalid high in the cycle after accept.
- sd ×4 to 0x8000_0000/08/10/18 with mem_wready = 0:
  - after the 4th accept, st_ready = 0
  - raise mem_wready → entries drain in order, one per cycle; st_ready returns 1 the cycle after the first pop.
- Buffer holds sw to 0x8000_0104; ld_addr 0x8000_0100 → ld_hazard = 1; ld_addr 0x8000_0108 → ld_hazard = 0.
- Two entries pending, fence_req = 1, mem_wready = 1:
  - st_ready = 0 during DRAIN
  - fence_done pulses exactly once, in the cycle count reaches 0
  - FSM returns to IDLE.
- Full buffer with rst pulled low for one edge → mem_wvalid = 0 next cycle, count = 0, no further writes.
- Misaligned sh at 0x8000_0007:
  - with macro: st_misalign pulses, no write
  - without macro: mem_wmask 0x80, mem_wdata carries only the low byte in lane 7.
